clk_rst_sequencer: RTL

- Synthesizable startup and health sequencer for the HDMI clocking resource: the PLL/MMCM that produces the pixel and 5x serial clocks.
- Pulses the PLL reset and waits for a jitter-tolerant stable lock. It then releases the serializer reset, then the video-timing reset, in a fixed order.
- Restarts the PLL on lock loss. Gives up after a bounded number of lock timeouts.
- Sits in the top level between the PLL primitive and the TMDS/video datapath. Runs on the free-running board clock.

---
 rtl/clk_rst_sequencer_pkg.sv | 16 +
 rtl/clk_rst_sequencer_if.sv | 21 ++
 rtl/clk_rst_sequencer_sync_2ff.sv | 24 ++
 rtl/clk_rst_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/clk_rst_sequencer_pkg.sv
// Shared constants for the HDMI clock/reset sequencer: FSM state encodings
// and the width of the shared cycle counter.
package clk_rst_sequencer_pkg;

  localparam int CNT_W = 32;

  typedef logic [2:0] state_t;

  localparam state_t PLL_RST    = 3'd0;
  localparam state_t WAIT_LOCK  = 3'd1;
  localparam state_t STABLE     = 3'd2;
  localparam state_t REL_SERDES = 3'd3;
  localparam state_t RUN        = 3'd4;
  localparam state_t FAIL       = 3'd5;

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// PLL-side and datapath-side control signals of the sequencer.
// master = sequencer, slave = PLL primitive / datapath resets.
interface clk_rst_sequencer_if;
  logic       pll_locked;
  logic       pll_rst;
  logic       serdes_rstn;
  logic       video_rstn;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;

  modport master (
    input  pll_locked,
    output pll_rst, serdes_rstn, video_rstn, ready, fail, retry_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst, serdes_rstn, video_rstn, ready, fail, retry_cnt
  );
endinterface

// File: rtl/clk_rst_sequencer_sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
// Also intended for hot-plug detect and other slow async flags.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_rst_sequencer.sv
// PLL bring-up sequencer: PLL reset pulse, stable-lock qualification, then
// serdes release followed by video release. Retries on timeout, restarts on
// lock loss. Latency from rstn rise (lock already high) to ready, in clk
// edges: max(RST_HOLD_CYCLES,2) + 1 + LOCK_STABLE_CYCLES + STAGE_GAP_CYCLES.
module clk_rst_sequencer
  import clk_rst_sequencer_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRY           = 3
) (
  input  logic                clk,
  input  logic                rstn,
  clk_rst_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

  logic             locked_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       retry_q, retry_n;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.pll_locked),
    .q    (locked_s)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry_q;
    case (state)
      PLL_RST: begin
        if (cnt == HOLD_LAST) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_n = FAIL;
          end else begin
            retry_n = retry_q + 4'd1;
            state_n = PLL_RST;
          end
        end
      end
      STABLE: begin
        if (!locked_s)                state_n = WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_n = REL_SERDES;
      end
      REL_SERDES: begin
        if (!locked_s) begin
          state_n = PLL_RST;
          retry_n = 4'd0;
        end else if (cnt == GAP_LAST) begin
          state_n = RUN;
        end
      end
      RUN: begin
        cnt_n = cnt;
        if (!locked_s) begin
          state_n = PLL_RST;
          retry_n = 4'd0;
        end
      end
      FAIL: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = PLL_RST;
      end
    endcase
    // A fresh state always starts counting from zero
    if (state_n != state) cnt_n = '0;
  end

  // Outputs are decoded from the next state so they switch on the same edge as the FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= PLL_RST;
      cnt             <= '0;
      retry_q         <= 4'd0;
      bus.pll_rst     <= 1'b1;
      bus.serdes_rstn <= 1'b0;
      bus.video_rstn  <= 1'b0;
      bus.ready       <= 1'b0;
      bus.fail        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      retry_q         <= retry_n;
      bus.pll_rst     <= (state_n == PLL_RST) || (state_n == FAIL);
      bus.serdes_rstn <= (state_n == REL_SERDES) || (state_n == RUN);
      bus.video_rstn  <= (state_n == RUN);
      bus.ready       <= (state_n == RUN);
      bus.fail        <= (state_n == FAIL);
    end
  end

  assign bus.retry_cnt = retry_q;

  a_release_order: assert property (@(posedge clk) disable iff (!rstn)
    (!bus.video_rstn || bus.serdes_rstn) && (!bus.serdes_rstn || !bus.pll_rst));

endmodule
